// File: rtl/risc8_bus_arb.sv
// risc8_bus_arb: shares the risc8 external memory bus between the CPU bus
// interface unit and a DMA requester. The CPU has priority and is parked on
// the bus when idle. Two saturating-free counters bound starvation both ways:
// starve_cnt counts CPU completions while DMA waits, and burst_cnt counts DMA
// completions while the CPU waits.
module risc8_bus_arb #(
  parameter int CPU_MAX = 4,  // CPU cycles granted while DMA waits (1..15)
  parameter int DMA_MAX = 2   // DMA cycles granted while CPU waits (1..15)
) (
  input  logic        clk,
  input  logic        rst,
  // CPU bus-cycle side
  input  logic        cpu_cycle,
  input  logic        cpu_write,
  input  logic        cpu_ifetch,
  input  logic        cpu_iack,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_out,
  output logic        cpu_ready,
  // DMA requester side
  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [15:0] dma_address,
  input  logic [7:0]  dma_data_out,
  output logic        dma_ack,
  output logic        grant_dma,
  // memory port
  output logic        mem_cycle,
  output logic        mem_write,
  output logic        mem_ifetch,
  output logic        mem_iack,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data_out,
  input  logic        mem_ready
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } own_t;

  localparam logic [3:0] CPU_LAST = 4'(CPU_MAX - 1);
  localparam logic [3:0] DMA_LAST = 4'(DMA_MAX - 1);

  own_t       own, own_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic [3:0] burst_cnt, burst_nxt;

  // Ownership and starvation counters.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it lives inside the
    // clocked branch rather than in the sensitivity list.
    if (rst) begin
      own        <= OWN_CPU;
      starve_cnt <= 4'd0;
      burst_cnt  <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // values seen before the edge, independent of statement order.
      own        <= own_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  // Next owner: switching happens only when the owner is idle or its cycle
  // completes, so an iack (or any) cycle is never split between masters.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    own_nxt    = own;
    starve_nxt = starve_cnt;
    burst_nxt  = burst_cnt;
    unique case (own)
      OWN_CPU: begin
        if (!dma_req) begin
          starve_nxt = 4'd0;
        end else if (!cpu_cycle) begin
          own_nxt = OWN_DMA;
        end else if (mem_ready) begin
          if (starve_cnt == CPU_LAST) own_nxt = OWN_DMA;
          else                        starve_nxt = starve_cnt + 4'd1;
        end
      end
      OWN_DMA: begin
        if (!dma_req) begin
          own_nxt = OWN_CPU;  // DMA is never parked
        end else if (mem_ready) begin
          if (!cpu_cycle)                   burst_nxt = 4'd0;
          else if (burst_cnt == DMA_LAST)   own_nxt   = OWN_CPU;
          else                              burst_nxt = burst_cnt + 4'd1;
        end
      end
      default: own_nxt = OWN_CPU;
    endcase
    // A fresh owner always starts with clean counters.
    if (own_nxt != own) begin
      starve_nxt = 4'd0;
      burst_nxt  = 4'd0;
    end
  end

  // Bus mux and ready steering, purely combinational from the owner so a
  // handover costs no idle clock and mem_ready passes straight through.
  always_comb begin
    mem_cycle    = cpu_cycle;
    mem_write    = cpu_write;
    mem_ifetch   = cpu_ifetch;
    mem_iack     = cpu_iack;
    mem_address  = cpu_address;
    mem_data_out = cpu_data_out;
    cpu_ready    = mem_ready;
    dma_ack      = 1'b0;
    if (own == OWN_DMA) begin
      mem_cycle    = dma_req;
      mem_write    = dma_write;
      mem_ifetch   = 1'b0;
      mem_iack     = 1'b0;
      mem_address  = dma_address;
      mem_data_out = dma_data_out;
      cpu_ready    = 1'b0;
      // A reset landing on a DMA cycle abandons it without acknowledging.
      dma_ack      = dma_req & mem_ready & ~rst;
    end
  end

  assign grant_dma = (own == OWN_DMA);

endmodule

// File: tb/tb_risc8_bus_arb.sv
// Bench for risc8_bus_arb: directed scenarios plus a randomized run checked
// against a behavioural model that tracks only the current owner and the
// length of its uninterrupted streak while the other master waits.
module tb_risc8_bus_arb;

  localparam int CPU_MAX = 4;
  localparam int DMA_MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_cycle, cpu_write, cpu_ifetch, cpu_iack;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_out;
  logic        cpu_ready;
  logic        dma_req, dma_write;
  logic [15:0] dma_address;
  logic [7:0]  dma_data_out;
  logic        dma_ack, grant_dma;
  logic        mem_cycle, mem_write, mem_ifetch, mem_iack;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_out;
  logic        mem_ready;

  int errors = 0;
  int checks = 0;

  // Reference model state: who owns the bus and how many back-to-back
  // completions the owner has had while the other master was waiting.
  bit m_dma;
  int m_streak;

  always #5 clk = ~clk;

  risc8_bus_arb #(.CPU_MAX(CPU_MAX), .DMA_MAX(DMA_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_cycle(cpu_cycle), .cpu_write(cpu_write), .cpu_ifetch(cpu_ifetch),
    .cpu_iack(cpu_iack), .cpu_address(cpu_address), .cpu_data_out(cpu_data_out),
    .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_write(dma_write), .dma_address(dma_address),
    .dma_data_out(dma_data_out), .dma_ack(dma_ack), .grant_dma(grant_dma),
    .mem_cycle(mem_cycle), .mem_write(mem_write), .mem_ifetch(mem_ifetch),
    .mem_iack(mem_iack), .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready)
  );

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_step();
    bit active, rival;
    int limit;
    if (rst) begin
      m_dma = 1'b0; m_streak = 0;
      return;
    end
    active = m_dma ? dma_req : cpu_cycle;
    rival  = m_dma ? cpu_cycle : dma_req;
    limit  = m_dma ? DMA_MAX : CPU_MAX;
    if (!active) begin
      if (m_dma || dma_req) begin m_dma = !m_dma; m_streak = 0; end
      else m_streak = 0;
    end else if (mem_ready) begin
      if (!rival)                      m_streak = 0;
      else if (m_streak + 1 == limit) begin m_dma = !m_dma; m_streak = 0; end
      else                             m_streak++;
    end else if (!m_dma && !dma_req) begin
      m_streak = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_cycle = 0; cpu_write = 0; cpu_ifetch = 0; cpu_iack = 0;
    cpu_address = 16'h0000; cpu_data_out = 8'h00;
    dma_req = 0; dma_write = 0; dma_address = 16'h0000; dma_data_out = 8'h00;
    mem_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; dma_req = 1; mem_ready = 1;
    cpu_address = 16'hABCD; dma_address = 16'h1111;
    tick(); tick();
    at_neg();
    checks++;
    if ({grant_dma, dma_ack} !== 2'b00) begin
      errors++; $display("FAIL reset_grant_ack: got %b expected 00", {grant_dma, dma_ack});
    end
    checks++;
    if (mem_address !== 16'hABCD) begin
      errors++; $display("FAIL reset_mem_address: got %h expected abcd", mem_address);
    end
    rst = 0; mem_ready = 0;
    tick();
    at_neg();
    checks++;
    if ({grant_dma, mem_cycle, mem_address} !== {2'b11, 16'h1111}) begin
      errors++; $display("FAIL reset_release_grant: got %h expected %h",
                         {grant_dma, mem_cycle, mem_address}, {2'b11, 16'h1111});
    end
    dma_req = 0;
    tick();
    at_neg();
    checks++;
    if (grant_dma !== 1'b0) begin
      errors++; $display("FAIL reset_release_drop: got %b expected 0", grant_dma);
    end
  endtask

  task automatic test_dma_read();
    int  acks;
    bit  cpu_rdy_seen;
    acks = 0; cpu_rdy_seen = 0;
    do_reset();
    cpu_address = 16'h4444;
    dma_req = 1; dma_address = 16'h1234;
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      at_neg();
      checks++;
      if ({grant_dma, mem_cycle, mem_write, mem_address} !== {3'b110, 16'h1234}) begin
        errors++; $display("FAIL dma_read_bus[%0d]: got %h expected %h", i,
                           {grant_dma, mem_cycle, mem_write, mem_address}, {3'b110, 16'h1234});
      end
      acks += int'(dma_ack);
      cpu_rdy_seen |= cpu_ready;
      tick();
    end
    dma_req = 0; mem_ready = 0;
    at_neg();
    acks += int'(dma_ack);
    cpu_rdy_seen |= cpu_ready;
    checks++;
    if (grant_dma !== 1'b1) begin
      errors++; $display("FAIL dma_read_hold_after_ack: got %b expected 1", grant_dma);
    end
    tick();
    at_neg();
    checks++;
    if (grant_dma !== 1'b0) begin
      errors++; $display("FAIL dma_read_release: got %b expected 0", grant_dma);
    end
    checks++;
    if (acks != 1 || cpu_rdy_seen) begin
      errors++; $display("FAIL dma_read_acks: got acks=%0d cpu_ready_seen=%0b expected acks=1 cpu_ready_seen=0",
                         acks, cpu_rdy_seen);
    end
  endtask

  task automatic test_cpu_max_pattern();
    logic [3:0] exp;
    do_reset();
    cpu_cycle = 1; cpu_ifetch = 1; cpu_address = 16'h0100;
    dma_req = 1; dma_address = 16'h8000; mem_ready = 1;
    for (int i = 0; i < 3 * (CPU_MAX + DMA_MAX); i++) begin
      at_neg();
      // {cpu_ready, dma_ack, mem_ifetch, grant_dma}
      exp = ((i % (CPU_MAX + DMA_MAX)) < CPU_MAX) ? 4'b1010 : 4'b0101;
      checks++;
      if ({cpu_ready, dma_ack, mem_ifetch, grant_dma} !== exp) begin
        errors++; $display("FAIL share_pattern[%0d]: got %b expected %b", i,
                           {cpu_ready, dma_ack, mem_ifetch, grant_dma}, exp);
      end
      tick();
    end
  endtask

  task automatic test_iack_atomic();
    do_reset();
    cpu_cycle = 1; cpu_iack = 1; cpu_address = 16'h00FE;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) dma_req = 1;
      mem_ready = (i == 3);
      at_neg();
      checks++;
      if ({mem_iack, grant_dma, cpu_ready} !== {2'b10, (i == 3)}) begin
        errors++; $display("FAIL iack_atomic[%0d]: got %b expected %b", i,
                           {mem_iack, grant_dma, cpu_ready}, {2'b10, (i == 3)});
      end
      tick();
    end
    cpu_cycle = 0; cpu_iack = 0; mem_ready = 0;
    tick();
    at_neg();
    checks++;
    if ({grant_dma, mem_cycle, mem_iack} !== 3'b110) begin
      errors++; $display("FAIL iack_then_dma: got %b expected 110", {grant_dma, mem_cycle, mem_iack});
    end
  endtask

  task automatic test_cpu_held();
    do_reset();
    dma_req = 1; dma_address = 16'h2000;
    tick();
    cpu_cycle = 1; cpu_write = 1; cpu_address = 16'h0F00; cpu_data_out = 8'h55;
    mem_ready = 1;
    for (int i = 0; i < DMA_MAX; i++) begin
      at_neg();
      checks++;
      if ({grant_dma, cpu_ready, dma_ack, mem_address} !== {3'b101, 16'h2000}) begin
        errors++; $display("FAIL cpu_held[%0d]: got %h expected %h", i,
                           {grant_dma, cpu_ready, dma_ack, mem_address}, {3'b101, 16'h2000});
      end
      tick();
    end
    at_neg();
    checks++;
    if ({grant_dma, mem_cycle, mem_write, mem_address, mem_data_out, cpu_ready, dma_ack}
        !== {3'b011, 16'h0F00, 8'h55, 2'b10}) begin
      errors++; $display("FAIL cpu_handover: got %h expected %h",
                         {grant_dma, mem_cycle, mem_write, mem_address, mem_data_out, cpu_ready, dma_ack},
                         {3'b011, 16'h0F00, 8'h55, 2'b10});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_dma();
    do_reset();
    cpu_address = 16'h5A5A;
    dma_req = 1; dma_address = 16'h3000;
    tick();
    at_neg();
    checks++;
    if ({grant_dma, dma_ack} !== 2'b10) begin
      errors++; $display("FAIL reset_mid_setup: got %b expected 10", {grant_dma, dma_ack});
    end
    rst = 1; mem_ready = 1;
    #1;
    checks++;
    if (dma_ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid_ack: got %b expected 0", dma_ack);
    end
    tick();
    at_neg();
    checks++;
    if ({grant_dma, dma_ack, mem_address} !== {2'b00, 16'h5A5A}) begin
      errors++; $display("FAIL reset_mid_after: got %h expected %h",
                         {grant_dma, dma_ack, mem_address}, {2'b00, 16'h5A5A});
    end
    rst = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [30:0] exp, got;
    bit          cpu_done, dma_done;
    int          n_cpu, n_dma, kind;
    n_cpu = 0; n_dma = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!cpu_cycle && $urandom_range(0, 3) != 0) begin
        kind = int'($urandom_range(0, 3));
        cpu_cycle = 1; cpu_write = (kind == 1); cpu_ifetch = (kind == 2); cpu_iack = (kind == 3);
        cpu_address = 16'($urandom); cpu_data_out = 8'($urandom);
      end
      if (!dma_req && $urandom_range(0, 2) == 0) begin
        dma_req = 1; dma_write = 1'($urandom);
        dma_address = 16'($urandom); dma_data_out = 8'($urandom);
      end
      mem_ready = 1'($urandom);
      at_neg();
      exp = m_dma ? {1'b1, dma_req, dma_write, 2'b00, dma_address, dma_data_out, 1'b0, dma_req & mem_ready}
                  : {1'b0, cpu_cycle, cpu_write, cpu_ifetch, cpu_iack, cpu_address, cpu_data_out, mem_ready, 1'b0};
      got = {grant_dma, mem_cycle, mem_write, mem_ifetch, mem_iack, mem_address, mem_data_out, cpu_ready, dma_ack};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_outputs[%0d]: got %h expected %h", i, got, exp);
      end
      cpu_done = !m_dma && cpu_cycle && mem_ready;
      dma_done = m_dma && dma_req && mem_ready;
      tick();
      if (cpu_done) begin
        n_cpu++; cpu_cycle = 0; cpu_write = 0; cpu_ifetch = 0; cpu_iack = 0;
      end
      if (dma_done) begin
        n_dma++; dma_req = 0;
      end
    end
    checks++;
    if (n_cpu == 0 || n_dma == 0) begin
      errors++; $display("FAIL random_progress: got cpu=%0d dma=%0d expected both nonzero", n_cpu, n_dma);
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_dma_read();
    test_cpu_max_pattern();
    test_iack_atomic();
    test_cpu_held();
    test_reset_mid_dma();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
